seq_detect_ctrl: RTL and testbench
==================================

Name: seq_detect_ctrl

Overview:
- Sequencing controller for the serial 1011 sequence detector.
- Accepts parallel words from a valid/ready source and shifts them MSB-first into the detector, one bit per clock.
- Drives the detector's reset, counts reported matches, and raises `done` when a programmed match threshold is reached.
- Sits between a bus-side producer and one detector instance.

Parameters:
- WORD_W, 8, width of input data word (bits shifted per word)
- CNT_W, 8, width of match counter and threshold

Ports:
- clk  input  1  system clock, all logic on posedge
- reset  input  1  synchronous, active-high reset
- start  input  1  pulse; clear count, reset detector, begin run (also restarts a running or finished run)
- stop  input  1  pulse; abort run, return to IDLE
- threshold  input  CNT_W  matches required for done; sampled every cycle; 0 = never done
- in_valid  input  1  source word valid
- in_ready  output  1  controller accepts word this cycle
- in_data  input  WORD_W  source word, MSB shifted first
- det_bit  output  1  serial bit to detector
- det_reset  output  1  synchronous reset to detector
- det_seen  input  1  detector match flag (registered state decode)
- match_count  output  CNT_W  matches counted this run
- busy  output  1  state is CLEAR, LOAD or SHIFT
- done  output  1  threshold reached; sticky until start or reset

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=0, det_bit=0, det_reset=1, match_count=0, busy=0, done=0, shift reg=0, bit index=0. Reset mid-operation discards any partial word.
- States: IDLE, CLEAR, LOAD, SHIFT, DONE.
- IDLE:
  - det_reset=1, in_ready=0.
  - start -> CLEAR.
- CLEAR (exactly 1 cycle):
  - det_reset=1; match_count<=0; done<=0.
  - -> LOAD.
- LOAD:
  - det_reset=1, in_ready=1.
  - in_valid -> shreg<=in_data, idx<=WORD_W-1, -> SHIFT.
- SHIFT:
  - det_reset=0; det_bit=shreg[WORD_W-1]; shreg shifts left 1 per cycle; idx decrements.
  - in_ready=1 only when idx==0.
  - idx==0 with in_valid: load next word, stay SHIFT, giving a gapless stream.
  - idx==0 without in_valid: -> LOAD.
- Gaps: a gap of one or more cycles resets the detector. Patterns never span a gap; they do span back-to-back words.
- det_bit=0 in every state other than SHIFT.
- Counting:
  - In LOAD or SHIFT, det_seen=1 increments match_count (saturating at all-ones).
  - det_seen rises the cycle after the 4th pattern bit is driven; a match on a word's last bit is counted in the following LOAD/SHIFT cycle.
- Completion:
  - When the increment makes match_count==threshold and threshold!=0: done<=1, -> DONE.
  - Any remaining bits of the current word are discarded; in_ready=0 that cycle.
- DONE:
  - det_reset=1, in_ready=0; count and done held.
  - start -> CLEAR.
- stop in CLEAR/LOAD/SHIFT/DONE: -> IDLE next cycle. Count is held; done is unchanged; a partial word is discarded.
- Simultaneous start+stop: stop wins.
- start in LOAD/SHIFT: -> CLEAR (restart).
- Detector overlap: after a match, next bit 1 resumes as prefix "1"; next bit 0 resumes as "10".

Test Plan:
- Reset, threshold=0, start, one word 0xB6 -> stream 1,0,1,1,0,1,1,0; det_seen high 1 cycle after bits 4 and 7; match_count=2; done=0; controller returns to LOAD with in_ready=1.
- threshold=3, words 0xB6 then 0xD8 back-to-back (in_valid held) -> third match spans words (2nd bit of 0xD8); done=1, match_count=3, state DONE, remaining 6 bits not driven, in_ready=0.
- threshold=0, 0x05 then 0x80 contiguous -> match_count=1. Repeat with a 2-cycle in_valid gap between the words -> det_reset high during the gap, match_count=0.
- stop asserted at the 3rd bit of 0xB6 -> IDLE next cycle, match_count held at 0, det_reset=1. Then start+stop in the same cycle -> stays IDLE. Then start alone -> CLEAR, count 0, busy=1.
- reset asserted mid-SHIFT after one match -> next cycle all outputs at reset values (match_count=0, done=0, det_reset=1); a subsequent start begins a clean run.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: feeds valid/ready words MSB-first into a 1011 detector, counts its matches and flags done at threshold
module seq_detect_ctrl #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [CNT_W-1:0]  threshold,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              det_bit,
  output logic              det_reset,
  input  logic              det_seen,
  output logic [CNT_W-1:0]  match_count,
  output logic              busy,
  output logic              done
);
  localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, LOAD = 3'd2, SHIFT = 3'd3, DONE = 3'd4;
  localparam int IW = WORD_W > 1 ? $clog2(WORD_W) : 1;
  logic [2:0] state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic done_q, done_d;
  logic run, count_en, hit, take;
  assign run = state_q == LOAD || state_q == SHIFT;
  assign count_en = run && det_seen && !stop && !start;
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
  assign hit = count_en && threshold != '0 && cnt_inc == threshold;
  assign in_ready = (state_q == LOAD || (state_q == SHIFT && idx_q == '0)) && !stop && !start && !hit;
  assign take = in_ready && in_valid;
  assign det_bit = state_q == SHIFT && !hit ? shreg_q[WORD_W-1] : 1'b0;
  assign det_reset = state_q != SHIFT;
  assign busy = state_q == CLEAR || run;
  assign match_count = cnt_q;
  assign done = done_q;
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d = idx_q;
    cnt_d = count_en ? cnt_inc : cnt_q;
    done_d = done_q | hit;
    if (state_q == SHIFT) begin
      shreg_d = shreg_q << 1;
      idx_d = idx_q - 1'b1;
      state_d = idx_q == '0 ? LOAD : SHIFT;
    end
    if (take) begin
      shreg_d = in_data;
      idx_d = IW'(WORD_W - 1);
      state_d = SHIFT;
    end
    if (state_q == CLEAR) begin
      cnt_d = '0;
      done_d = 1'b0;
      state_d = LOAD;
    end
    if (hit || start || stop) begin
      shreg_d = '0;
      idx_d = '0;
      state_d = hit ? DONE : CLEAR;
    end
    if (stop) begin
      cnt_d = cnt_q;
      done_d = done_q;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: directed bench for seq_detect_ctrl driving a behavioural 1011 detector
module tb_seq_detect_ctrl;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, in_valid = 1'b0;
  logic [7:0] threshold = '0, in_data = '0, match_count;
  logic in_ready, det_bit, det_reset, busy, done, det_seen;
  logic [2:0] ds_q;
  int total = 0, passed = 0;
  seq_detect_ctrl #(.WORD_W(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .threshold(threshold),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .det_bit(det_bit),
    .det_reset(det_reset), .det_seen(det_seen), .match_count(match_count), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (det_reset) ds_q <= 3'd0;
    else case (ds_q)
      3'd0: ds_q <= det_bit ? 3'd1 : 3'd0;
      3'd1: ds_q <= det_bit ? 3'd1 : 3'd2;
      3'd2: ds_q <= det_bit ? 3'd3 : 3'd0;
      3'd3: ds_q <= det_bit ? 3'd4 : 3'd2;
      default: ds_q <= det_bit ? 3'd1 : 3'd2;
    endcase
  assign det_seen = ds_q == 3'd4;
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic send(input logic [7:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_data = w;
    #1;
    while (!in_ready && n < 40) begin tick(); n++; end
    total++;
    if (!in_ready) $display("FAIL send_accept: in_ready=%0b required 1 for word %h", in_ready, w); else passed++;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %0b want 0", done); else passed++;
    total++; if (match_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", match_count); else passed++;
    total++; if (det_reset !== 1'b1) $display("FAIL reset_det_reset: got %0b want 1", det_reset); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0b want 0", in_ready); else passed++;
    total++; if (det_bit !== 1'b0) $display("FAIL reset_det_bit: got %0b want 0", det_bit); else passed++;
    reset = 1'b0;
  endtask
  task automatic test_single_word();
    logic [7:0] w = 8'hB6;
    threshold = 8'd0;
    pulse_start();
    send(w);
    for (int i = 0; i < 8; i++) begin
      total++; if (det_bit !== w[7-i]) $display("FAIL stream_bit%0d: got %0b want %0b", i, det_bit, w[7-i]); else passed++;
      total++; if (det_seen !== (i == 4 || i == 7)) $display("FAIL seen_cycle%0d: got %0b want %0b", i, det_seen, i == 4 || i == 7); else passed++;
      tick();
    end
    total++; if (match_count !== 8'd2) $display("FAIL single_count: got %0d want 2", match_count); else passed++;
    total++; if (done !== 1'b0) $display("FAIL single_done: got %0b want 0", done); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL single_load_ready: got %0b want 1", in_ready); else passed++;
    total++; if (det_reset !== 1'b1) $display("FAIL single_load_det_reset: got %0b want 1", det_reset); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL single_busy: got %0b want 1", busy); else passed++;
  endtask
  task automatic test_back_to_back();
    threshold = 8'd3;
    pulse_start();
    send(8'hB6);
    send(8'hD8);
    total++; if (match_count !== 8'd2) $display("FAIL b2b_mid_count: got %0d want 2", match_count); else passed++;
    tick();
    tick();
    total++; if (in_ready !== 1'b0) $display("FAIL b2b_hit_ready: got %0b want 0", in_ready); else passed++;
    total++; if (det_bit !== 1'b0) $display("FAIL b2b_hit_bit: got %0b want 0", det_bit); else passed++;
    tick();
    total++; if (done !== 1'b1) $display("FAIL b2b_done: got %0b want 1", done); else passed++;
    total++; if (match_count !== 8'd3) $display("FAIL b2b_count: got %0d want 3", match_count); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL b2b_busy: got %0b want 0", busy); else passed++;
    total++; if (det_reset !== 1'b1) $display("FAIL b2b_det_reset: got %0b want 1", det_reset); else passed++;
    in_valid = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL done_in_ready: got %0b want 0", in_ready); else passed++;
    in_valid = 1'b0;
    repeat (6) tick();
    total++; if (match_count !== 8'd3 || det_bit !== 1'b0) $display("FAIL done_hold: count=%0d bit=%0b want 3/0", match_count, det_bit); else passed++;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL stop_from_done: done=%0b busy=%0b want 1/0", done, busy); else passed++;
  endtask
  task automatic test_gap();
    threshold = 8'd0;
    pulse_start();
    send(8'h05);
    send(8'h80);
    repeat (9) tick();
    total++; if (match_count !== 8'd1) $display("FAIL span_count: got %0d want 1", match_count); else passed++;
    total++; if (done !== 1'b0) $display("FAIL restart_clears_done: got %0b want 0", done); else passed++;
    pulse_start();
    send(8'h05);
    repeat (8) tick();
    total++; if (det_reset !== 1'b1 || in_ready !== 1'b1) $display("FAIL gap1: det_reset=%0b in_ready=%0b want 1/1", det_reset, in_ready); else passed++;
    tick();
    total++; if (det_reset !== 1'b1) $display("FAIL gap2_det_reset: got %0b want 1", det_reset); else passed++;
    tick();
    send(8'h80);
    repeat (10) tick();
    total++; if (match_count !== 8'd0) $display("FAIL gap_count: got %0d want 0", match_count); else passed++;
  endtask
  task automatic test_stop();
    pulse_start();
    send(8'hB6);
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL stop_busy: got %0b want 0", busy); else passed++;
    total++; if (det_reset !== 1'b1) $display("FAIL stop_det_reset: got %0b want 1", det_reset); else passed++;
    total++; if (match_count !== 8'd0) $display("FAIL stop_count: got %0d want 0", match_count); else passed++;
    total++; if (in_ready !== 1'b0 || det_bit !== 1'b0) $display("FAIL stop_idle_io: ready=%0b bit=%0b want 0/0", in_ready, det_bit); else passed++;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL start_stop_busy: got %0b want 0", busy); else passed++;
    pulse_start();
    total++; if (busy !== 1'b1) $display("FAIL clear_busy: got %0b want 1", busy); else passed++;
    total++; if (in_ready !== 1'b0 || det_reset !== 1'b1) $display("FAIL clear_io: ready=%0b det_reset=%0b want 0/1", in_ready, det_reset); else passed++;
  endtask
  task automatic test_mid_reset();
    send(8'hB6);
    repeat (5) tick();
    total++; if (match_count !== 8'd1) $display("FAIL pre_reset_count: got %0d want 1", match_count); else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (match_count !== 8'd0 || done !== 1'b0) $display("FAIL midreset_count_done: count=%0d done=%0b want 0/0", match_count, done); else passed++;
    total++; if (det_reset !== 1'b1 || busy !== 1'b0) $display("FAIL midreset_state: det_reset=%0b busy=%0b want 1/0", det_reset, busy); else passed++;
    total++; if (in_ready !== 1'b0 || det_bit !== 1'b0) $display("FAIL midreset_io: ready=%0b bit=%0b want 0/0", in_ready, det_bit); else passed++;
    pulse_start();
    send(8'hB6);
    repeat (8) tick();
    total++; if (match_count !== 8'd2) $display("FAIL clean_run_count: got %0d want 2", match_count); else passed++;
  endtask
  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_gap();
    test_stop();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
